// File: rtl/tag_chip_pkg.sv
// rtl/tag_chip_pkg.sv - shared constants for the tag-chip multi-tone TX path
package tag_chip_pkg;

  localparam int TC_PHASE_WIDTH   = 24;
  localparam int TC_BIT_CNT_WIDTH = 7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_HOP  = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;

endpackage

// File: rtl/tag_symb_timer.sv
// rtl/tag_symb_timer.sv - per-symbol sample counter with boundary strobes and symbol-rate hop clock
module tag_symb_timer #(
  parameter int NSIG = 8192
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_clear,
  input  logic                    i_data,
  output logic [$clog2(NSIG)-1:0] o_sig_cnt,
  output logic                    o_boundary,
  output logic                    o_pre_boundary,
  output logic                    o_hop_clk
);

  localparam int SW = $clog2(NSIG);

  logic [SW-1:0] r_cnt;
  logic          r_hop_clk;
  logic [SW-1:0] w_cnt_nxt;

  // NSIG is a power of two, so the natural counter rollover is the symbol wrap
  always_comb begin
    w_cnt_nxt = i_clear ? '0 : r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_hop_clk <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_hop_clk <= i_data & ~w_cnt_nxt[SW-1];
    end
  end

  assign o_sig_cnt      = r_cnt;
  assign o_boundary     = &r_cnt;
  assign o_pre_boundary = (r_cnt == SW'(NSIG - 2));
  assign o_hop_clk      = r_hop_clk;

endmodule

// File: rtl/tag_hop_sched.sv
// rtl/tag_hop_sched.sv - frame sequencer: pilot sync, hop sweep, then LSB-first payload serialisation
module tag_hop_sched
  import tag_chip_pkg::*;
#(
  parameter int PHASE_WIDTH   = TC_PHASE_WIDTH,
  parameter int NSIG          = 8192,
  parameter int NSYNC         = 4,
  parameter int NHOP          = 16,
  parameter int HOP_PH_START  = 4096,
  parameter int HOP_PH_STEP   = 4096,
  parameter int TX_BITS_WIDTH = 128,
  parameter int BIT_CNT_WIDTH = TC_BIT_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [TX_BITS_WIDTH-1:0] tx_bits,
  input  logic [BIT_CNT_WIDTH-1:0] ntx_bits,
  output logic [PHASE_WIDTH-1:0]   hop_ph_inc,
  output logic [BIT_CNT_WIDTH-1:0] nhop,
  output logic                     tx_bit,
  output logic                     hop_clk,
  output logic                     hop_rst,
  output logic [BIT_CNT_WIDTH-1:0] ntx_bits_cnt,
  output logic [$clog2(NSIG)-1:0]  sig_cnt,
  output logic [1:0]               mtx_state,
  output logic                     busy,
  output logic                     done
);

  localparam int SYNC_W = (NSYNC > 1) ? $clog2(NSYNC) : 1;
  localparam logic [SYNC_W-1:0]        SYNC_LAST = SYNC_W'(NSYNC - 1);
  localparam logic [BIT_CNT_WIDTH-1:0] HOP_LAST  = BIT_CNT_WIDTH'(NHOP - 1);
  localparam logic [PHASE_WIDTH-1:0]   PH_START  = PHASE_WIDTH'(HOP_PH_START);
  localparam logic [PHASE_WIDTH-1:0]   PH_STEP   = PHASE_WIDTH'(HOP_PH_STEP);

  logic [1:0]               r_state;
  logic [TX_BITS_WIDTH-1:0] r_shift;
  logic [BIT_CNT_WIDTH-1:0] r_ntx;
  logic [BIT_CNT_WIDTH-1:0] r_nhop;
  logic [PHASE_WIDTH-1:0]   r_ph;
  logic [BIT_CNT_WIDTH-1:0] r_cnt;
  logic [SYNC_W-1:0]        r_sync;
  logic                     r_done;
  logic                     r_tx_bit;
  logic                     r_hop_rst;
  logic                     r_busy;

  logic [1:0]               w_state_nxt;
  logic [TX_BITS_WIDTH-1:0] w_shift_nxt;
  logic [BIT_CNT_WIDTH-1:0] w_ntx_nxt;
  logic [BIT_CNT_WIDTH-1:0] w_nhop_nxt;
  logic [PHASE_WIDTH-1:0]   w_ph_nxt;
  logic [BIT_CNT_WIDTH-1:0] w_cnt_nxt;
  logic [SYNC_W-1:0]        w_sync_nxt;
  logic                     w_done_nxt;
  logic                     w_clear;
  logic                     w_bnd;
  logic                     w_pre_bnd;
  logic                     w_hop_clk;
  logic [$clog2(NSIG)-1:0]  w_sig_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_ntx_nxt   = r_ntx;
    w_nhop_nxt  = r_nhop;
    w_ph_nxt    = r_ph;
    w_cnt_nxt   = r_cnt;
    w_sync_nxt  = r_sync;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = ST_SYNC;
          w_shift_nxt = tx_bits;
          w_ntx_nxt   = ntx_bits;
        end
      end
      ST_SYNC: begin
        if (w_bnd) begin
          if (r_sync == SYNC_LAST) begin
            w_state_nxt = ST_HOP;
            w_sync_nxt  = '0;
            w_nhop_nxt  = '0;
            w_ph_nxt    = PH_START;
          end else begin
            w_sync_nxt = r_sync + 1'b1;
          end
        end
      end
      ST_HOP: begin
        if (w_bnd) begin
          if (r_nhop == HOP_LAST) begin
            w_ph_nxt = '0;
            if (r_ntx != '0) begin
              w_state_nxt = ST_DATA;
            end else begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_nhop_nxt = r_nhop + 1'b1;
            w_ph_nxt   = r_ph + PH_STEP;
          end
        end
      end
      ST_DATA: begin
        // count the bit one clock early so the boundary cycle already shows it as sent
        if (w_pre_bnd) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
        if (w_bnd) begin
          if (r_cnt == r_ntx) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_shift_nxt = r_shift >> 1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_done_nxt  = 1'b0;
    end
    if (w_state_nxt == ST_IDLE) begin
      w_shift_nxt = '0;
      w_ntx_nxt   = '0;
      w_nhop_nxt  = '0;
      w_ph_nxt    = '0;
      w_cnt_nxt   = '0;
      w_sync_nxt  = '0;
    end
  end

  assign w_clear = (w_state_nxt != r_state) || (r_state == ST_IDLE);

  tag_symb_timer #(
    .NSIG(NSIG)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .i_clear       (w_clear),
    .i_data        (w_state_nxt == ST_DATA),
    .o_sig_cnt     (w_sig_cnt),
    .o_boundary    (w_bnd),
    .o_pre_boundary(w_pre_bnd),
    .o_hop_clk     (w_hop_clk)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_ntx     <= '0;
      r_nhop    <= '0;
      r_ph      <= '0;
      r_cnt     <= '0;
      r_sync    <= '0;
      r_done    <= 1'b0;
      r_tx_bit  <= 1'b0;
      r_hop_rst <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_ntx     <= w_ntx_nxt;
      r_nhop    <= w_nhop_nxt;
      r_ph      <= w_ph_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sync    <= w_sync_nxt;
      r_done    <= w_done_nxt;
      r_tx_bit  <= (w_state_nxt == ST_DATA) & w_shift_nxt[0];
      r_hop_rst <= (w_state_nxt == ST_IDLE);
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  assign hop_ph_inc   = r_ph;
  assign nhop         = r_nhop;
  assign tx_bit       = r_tx_bit;
  assign hop_clk      = w_hop_clk;
  assign hop_rst      = r_hop_rst;
  assign ntx_bits_cnt = r_cnt;
  assign sig_cnt      = w_sig_cnt;
  assign mtx_state    = r_state;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_tag_hop_sched.sv
// tb/tb_tag_hop_sched.sv - directed bench for tag_hop_sched with a second instance exercising phase wrap
module tb_tag_hop_sched;

  localparam int WRAP_START = 16777166;

  logic         clk = 1'b0;
  logic         reset, start, abort;
  logic [127:0] tx_bits;
  logic [6:0]   ntx_bits;

  logic [23:0] hop_ph_inc, wr_hop_ph_inc;
  logic [6:0]  nhop, wr_nhop, ntx_bits_cnt, wr_ntx_bits_cnt;
  logic        tx_bit, hop_clk, hop_rst, busy, done;
  logic        wr_tx_bit, wr_hop_clk, wr_hop_rst, wr_busy, wr_done;
  logic [2:0]  sig_cnt, wr_sig_cnt;
  logic [1:0]  mtx_state, wr_mtx_state;

  int cyc, n_assert, n_fail;

  tag_hop_sched #(
    .NSIG(8), .NSYNC(2), .NHOP(4), .HOP_PH_START(1000), .HOP_PH_STEP(100)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .tx_bits(tx_bits), .ntx_bits(ntx_bits),
    .hop_ph_inc(hop_ph_inc), .nhop(nhop), .tx_bit(tx_bit), .hop_clk(hop_clk),
    .hop_rst(hop_rst), .ntx_bits_cnt(ntx_bits_cnt), .sig_cnt(sig_cnt),
    .mtx_state(mtx_state), .busy(busy), .done(done)
  );

  tag_hop_sched #(
    .NSIG(8), .NSYNC(2), .NHOP(4), .HOP_PH_START(WRAP_START), .HOP_PH_STEP(100)
  ) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .tx_bits(tx_bits), .ntx_bits(ntx_bits),
    .hop_ph_inc(wr_hop_ph_inc), .nhop(wr_nhop), .tx_bit(wr_tx_bit), .hop_clk(wr_hop_clk),
    .hop_rst(wr_hop_rst), .ntx_bits_cnt(wr_ntx_bits_cnt), .sig_cnt(wr_sig_cnt),
    .mtx_state(wr_mtx_state), .busy(wr_busy), .done(wr_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_idle(input logic exp_done);
    chk("idle_state", 64'(mtx_state), 64'd0);
    chk("idle_hop_rst", 64'(hop_rst), 64'd1);
    chk("idle_ph", 64'(hop_ph_inc), 64'd0);
    chk("idle_nhop", 64'(nhop), 64'd0);
    chk("idle_tx_bit", 64'(tx_bit), 64'd0);
    chk("idle_hop_clk", 64'(hop_clk), 64'd0);
    chk("idle_cnt", 64'(ntx_bits_cnt), 64'd0);
    chk("idle_sig", 64'(sig_cnt), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'(exp_done));
    chk("idle_wrap_ph", 64'(wr_hop_ph_inc), 64'd0);
  endtask

  // Expected outputs rel cycles after the accepted start (start sampled at rel 0).
  task automatic check_frame(input int rel, input int n, input logic [127:0] data);
    int          done_c, k, s;
    logic [1:0]  e_state;
    logic [23:0] e_ph, e_wph;
    logic [6:0]  e_nhop, e_cnt;
    logic        e_bit, e_hclk;
    done_c = 49 + 8 * n;
    if (rel >= done_c) begin
      check_idle(rel == done_c);
      return;
    end
    e_ph = 24'd0; e_wph = 24'd0; e_nhop = 7'd0; e_cnt = 7'd0; e_bit = 1'b0; e_hclk = 1'b0;
    if (rel <= 16) begin
      e_state = 2'd1;
      s = (rel - 1) % 8;
    end else if (rel <= 48) begin
      e_state = 2'd2;
      k = (rel - 17) / 8;
      s = (rel - 17) % 8;
      e_nhop = 7'(k);
      e_ph = 24'(1000 + 100 * k);
      e_wph = 24'(WRAP_START + 100 * k);
    end else begin
      e_state = 2'd3;
      k = (rel - 49) / 8;
      s = (rel - 49) % 8;
      e_nhop = 7'd3;
      e_bit = data[k];
      e_hclk = (s < 4);
      e_cnt = 7'(k + ((s == 7) ? 1 : 0));
    end
    chk("state", 64'(mtx_state), 64'(e_state));
    chk("sig_cnt", 64'(sig_cnt), 64'(s));
    chk("hop_ph_inc", 64'(hop_ph_inc), 64'(e_ph));
    chk("wrap_hop_ph_inc", 64'(wr_hop_ph_inc), 64'(e_wph));
    chk("nhop", 64'(nhop), 64'(e_nhop));
    chk("tx_bit", 64'(tx_bit), 64'(e_bit));
    chk("hop_clk", 64'(hop_clk), 64'(e_hclk));
    chk("ntx_bits_cnt", 64'(ntx_bits_cnt), 64'(e_cnt));
    chk("hop_rst", 64'(hop_rst), 64'd0);
    chk("busy", 64'(busy), 64'd1);
    chk("done", 64'(done), 64'd0);
  endtask

  task automatic run_frame(input logic [127:0] data, input int n, input int last);
    tx_bits = data;
    ntx_bits = 7'(n);
    start = 1'b1;
    cyc = 0;
    while (cyc < last) begin
      step();
      start = 1'b0;
      check_frame(cyc, n, data);
    end
  endtask

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; tx_bits = '0; ntx_bits = '0;

    repeat (5) begin step(); check_idle(1'b0); end
    start = 1'b1; tx_bits = 128'hA; ntx_bits = 7'd4;
    repeat (5) begin step(); check_idle(1'b0); end
    reset = 1'b0; start = 1'b0;
    step(); check_idle(1'b0);

    run_frame(128'hA, 4, 83);

    run_frame(128'hFF, 0, 52);

    tx_bits = 128'hA; ntx_bits = 7'd4; start = 1'b1; cyc = 0;
    while (cyc < 30) begin step(); start = 1'b0; check_frame(cyc, 4, 128'hA); end
    abort = 1'b1;
    step(); abort = 1'b0; check_idle(1'b0);
    while (cyc < 40) begin step(); check_idle(1'b0); end
    start = 1'b1;
    while (cyc < 123) begin step(); start = 1'b0; check_frame(cyc - 40, 4, 128'hA); end

    tx_bits = 128'hA; ntx_bits = 7'd4; start = 1'b1; cyc = 0;
    while (cyc < 90) begin
      step();
      start = (cyc == 10 || cyc == 60);
      if (cyc == 20) begin tx_bits = 128'h5; ntx_bits = 7'd2; end
      check_frame(cyc, 4, 128'hA);
    end

    abort = 1'b1; start = 1'b1;
    step(); abort = 1'b0; start = 1'b0; check_idle(1'b0);
    step(); check_idle(1'b0);

    tx_bits = 128'h3; ntx_bits = 7'd2; start = 1'b1; cyc = 0;
    while (cyc < 20) begin step(); start = 1'b0; check_frame(cyc, 2, 128'h3); end
    reset = 1'b1;
    step(); reset = 1'b0; check_idle(1'b0);
    step(); check_idle(1'b0);

    run_frame(128'h1, 1, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
